// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit word memory-controller port between a CPU and a DMA/blitter requester.
// Latency: grant on the first IDLE edge that sees a request; enables held ACCESS_CYCLES cycles; ack/rdata one cycle later.
// Backpressure: the losing requester holds req until its ack; requests are only sampled in IDLE.
// Ports: clk, rst_n (async active-low); cpu_* and dma_* requester ports (req/we/addr/wdata in, rdata/ack out);
//        mc_* memory-controller side; busy (state != IDLE); owner (0 = CPU, 1 = DMA, current or last grant).
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests; default is fixed CPU priority.
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 3  // legal range 3..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [15:0] mc_address,
  output logic [15:0] mc_data_in,
  input  logic [15:0] mc_data_out,
  output logic        mc_read_en,
  output logic        mc_write_en,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_COMPLETE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic       last_owner;
  logic       grant_dma;

  // Winner selection, only meaningful while in IDLE with a request pending.
  always_comb begin
    grant_dma = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the port to whoever did not have it last.
    grant_dma = dma_req && (!cpu_req || !last_owner);
`else
    grant_dma = dma_req && !cpu_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      busy        <= 1'b0;
      mc_address  <= 16'h0000;
      mc_data_in  <= 16'h0000;
      mc_read_en  <= 1'b0;
      mc_write_en <= 1'b0;
      cpu_rdata   <= 16'h0000;
      dma_rdata   <= 16'h0000;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || dma_req) begin
            owner       <= grant_dma;
            last_owner  <= grant_dma;
            mc_address  <= grant_dma ? dma_addr  : cpu_addr;
            mc_data_in  <= grant_dma ? dma_wdata : cpu_wdata;
            we_q        <= grant_dma ? dma_we    : cpu_we;
            // Enables are registered here so they are high for the whole first ACCESS cycle.
            mc_read_en  <= grant_dma ? !dma_we   : !cpu_we;
            mc_write_en <= grant_dma ? dma_we    : cpu_we;
            cnt         <= 4'd0;
            busy        <= 1'b1;
            state       <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            // Leaving ACCESS: the controller has had the enable for ACCESS_CYCLES cycles,
            // so its read data is valid now and is captured into the owner's rdata.
            mc_read_en  <= 1'b0;
            mc_write_en <= 1'b0;
            if (!we_q) begin
              if (owner) dma_rdata <= mc_data_out;
              else       cpu_rdata <= mc_data_out;
            end
            cpu_ack <= !owner;
            dma_ack <= owner;
            state   <= S_COMPLETE;
          end
        end

        S_COMPLETE: begin
          // Enable-low cycle lets the controller's byte counter reset.
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          mc_read_en  <= 1'b0;
          mc_write_en <= 1'b0;
          cpu_ack     <= 1'b0;
          dma_ack     <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with hand-computed expectations.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] cpu_rdata, dma_rdata;
  logic        cpu_ack, dma_ack;
  logic [15:0] mc_address, mc_data_in, mc_data_out;
  logic        mc_read_en, mc_write_en, busy, owner;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observation accumulators filled by watch().
  int rd_cnt, wr_cnt, ack_cyc, cpu_ack_cnt, dma_ack_cnt, addr_bad, data_bad, both_ack, busy_bad;
  logic [15:0] exp_addr, exp_wdata;

  mem_arbiter #(.ACCESS_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mc_address(mc_address), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
    .mc_read_en(mc_read_en), .mc_write_en(mc_write_en), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs cycles (sampling at negedge) until an ack is seen or maxc cycles pass.
  task automatic watch(input int maxc);
    rd_cnt = 0; wr_cnt = 0; ack_cyc = 0; cpu_ack_cnt = 0; dma_ack_cnt = 0;
    addr_bad = 0; data_bad = 0; both_ack = 0; busy_bad = 0;
    for (int i = 1; i <= maxc && ack_cyc == 0; i++) begin
      step();
      if (mc_read_en) rd_cnt++;
      if (mc_write_en) wr_cnt++;
      if ((mc_read_en || mc_write_en) && mc_address !== exp_addr) addr_bad++;
      if (mc_write_en && mc_data_in !== exp_wdata) data_bad++;
      if ((mc_read_en || mc_write_en) && !busy) busy_bad++;
      if (cpu_ack) cpu_ack_cnt++;
      if (dma_ack) dma_ack_cnt++;
      if (cpu_ack && dma_ack) both_ack++;
      if (cpu_ack || dma_ack) ack_cyc = i;
    end
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if ({mc_read_en, mc_write_en} !== 2'b00) $display("FAIL reset_en got=%b exp=00", {mc_read_en, mc_write_en}); else pass_cnt++;
    total_cnt++; if ({cpu_ack, dma_ack} !== 2'b00) $display("FAIL reset_ack got=%b exp=00", {cpu_ack, dma_ack}); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (owner !== 1'b0) $display("FAIL reset_owner got=%b exp=0", owner); else pass_cnt++;
    total_cnt++; if (mc_address !== 16'h0000) $display("FAIL reset_addr got=%h exp=0000", mc_address); else pass_cnt++;
    total_cnt++; if (mc_data_in !== 16'h0000) $display("FAIL reset_wdata got=%h exp=0000", mc_data_in); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'h0000 || dma_rdata !== 16'h0000) $display("FAIL reset_rdata got=%h/%h exp=0000/0000", cpu_rdata, dma_rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 16'h0000;
    mc_data_out = 16'hBEEF; exp_addr = 16'h1234; exp_wdata = 16'h0000;
    watch(12);
    cpu_req = 1'b0;
    total_cnt++; if (rd_cnt != 3) $display("FAIL cpu_rd_len got=%0d exp=3", rd_cnt); else pass_cnt++;
    total_cnt++; if (wr_cnt != 0) $display("FAIL cpu_rd_wr_en got=%0d exp=0", wr_cnt); else pass_cnt++;
    total_cnt++; if (addr_bad != 0) $display("FAIL cpu_rd_addr bad_cycles=%0d exp=0", addr_bad); else pass_cnt++;
    total_cnt++; if (ack_cyc != 4) $display("FAIL cpu_rd_ack_cycle got=%0d exp=4", ack_cyc); else pass_cnt++;
    total_cnt++; if (cpu_ack_cnt != 1 || dma_ack_cnt != 0) $display("FAIL cpu_rd_acks got cpu=%0d dma=%0d exp 1/0", cpu_ack_cnt, dma_ack_cnt); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'hBEEF) $display("FAIL cpu_rd_data got=%h exp=beef", cpu_rdata); else pass_cnt++;
    total_cnt++; if (busy_bad != 0) $display("FAIL cpu_rd_busy bad_cycles=%0d exp=0", busy_bad); else pass_cnt++;
    mc_data_out = 16'h0000;
    step();
    total_cnt++; if (cpu_ack !== 1'b0) $display("FAIL cpu_ack_width got=%b exp=0", cpu_ack); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'hBEEF) $display("FAIL cpu_rdata_hold got=%h exp=beef", cpu_rdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL cpu_rd_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0800; dma_wdata = 16'hA55A;
    exp_addr = 16'h0800; exp_wdata = 16'hA55A;
    watch(12);
    dma_req = 1'b0;
    total_cnt++; if (wr_cnt != 3) $display("FAIL dma_wr_len got=%0d exp=3", wr_cnt); else pass_cnt++;
    total_cnt++; if (rd_cnt != 0) $display("FAIL dma_wr_rd_en got=%0d exp=0", rd_cnt); else pass_cnt++;
    total_cnt++; if (addr_bad != 0 || data_bad != 0) $display("FAIL dma_wr_bus bad addr=%0d data=%0d exp 0/0", addr_bad, data_bad); else pass_cnt++;
    total_cnt++; if (dma_ack_cnt != 1 || cpu_ack_cnt != 0) $display("FAIL dma_wr_acks got dma=%0d cpu=%0d exp 1/0", dma_ack_cnt, cpu_ack_cnt); else pass_cnt++;
    total_cnt++; if (owner !== 1'b1) $display("FAIL dma_wr_owner got=%b exp=1", owner); else pass_cnt++;
    step();
    total_cnt++; if (dma_ack !== 1'b0) $display("FAIL dma_ack_width got=%b exp=0", dma_ack); else pass_cnt++;
    total_cnt++; if (mc_data_in !== 16'hA55A) $display("FAIL dma_wr_data_kept got=%h exp=a55a", mc_data_in); else pass_cnt++;
  endtask

  task automatic test_arbitration();
    logic [3:0] ord;
    logic [3:0] exp_ord;
    int n_acks, dma_total, both;
    ord = 4'b0000; n_acks = 0; dma_total = 0; both = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    mc_data_out = 16'h3333;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cpu_ack && dma_ack) both++;
      if (dma_ack) dma_total++;
      if ((cpu_ack || dma_ack) && n_acks < 4) begin
        ord[n_acks] = dma_ack;
        n_acks++;
      end
      if (i == 20) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = 4'b1010;  // CPU, DMA, CPU, DMA (bit k = k-th ack was DMA)
`else
    exp_ord = 4'b0000;
`endif
    total_cnt++; if (n_acks != 4) $display("FAIL arb_ack_count got=%0d exp=4", n_acks); else pass_cnt++;
    total_cnt++; if (ord !== exp_ord) $display("FAIL arb_order got=%b exp=%b", ord, exp_ord); else pass_cnt++;
    total_cnt++; if (dma_total != int'(exp_ord[1]) + int'(exp_ord[3])) $display("FAIL arb_dma_acks got=%0d exp=%0d", dma_total, int'(exp_ord[1]) + int'(exp_ord[3])); else pass_cnt++;
    total_cnt++; if (both != 0) $display("FAIL arb_both_acks got=%0d exp=0", both); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL arb_drain_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first_rise, second_rise, gap, acks;
    logic prev_en, en;
    first_rise = 0; second_rise = 0; gap = 0; acks = 0; prev_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; mc_data_out = 16'h1111;
    for (int i = 1; i <= 10; i++) begin
      step();
      en = mc_read_en | mc_write_en;
      if (en && !prev_en) begin
        if (first_rise == 0) first_rise = i;
        else if (second_rise == 0) second_rise = i;
      end
      if (!en && first_rise != 0 && second_rise == 0) gap++;
      if (cpu_ack) acks++;
      prev_en = en;
      if (i == 10) cpu_req = 1'b0;
    end
    total_cnt++; if (first_rise != 1) $display("FAIL b2b_first_rise got=%0d exp=1", first_rise); else pass_cnt++;
    total_cnt++; if (second_rise != 6) $display("FAIL b2b_spacing got=%0d exp=6", second_rise); else pass_cnt++;
    total_cnt++; if (gap != 2) $display("FAIL b2b_gap got=%0d exp=2", gap); else pass_cnt++;
    total_cnt++; if (acks != 2) $display("FAIL b2b_acks got=%0d exp=2", acks); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_drain_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int acks;
    acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222; mc_data_out = 16'h7777;
    step();
    step();
    total_cnt++; if (mc_read_en !== 1'b1) $display("FAIL rst_mid_pre_en got=%b exp=1", mc_read_en); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({mc_read_en, mc_write_en} !== 2'b00) $display("FAIL rst_mid_en got=%b exp=00", {mc_read_en, mc_write_en}); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || owner !== 1'b0) $display("FAIL rst_mid_busy_owner got=%b%b exp=00", busy, owner); else pass_cnt++;
    total_cnt++; if (mc_address !== 16'h0000 || mc_data_in !== 16'h0000) $display("FAIL rst_mid_bus got=%h/%h exp=0000/0000", mc_address, mc_data_in); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'h0000 || dma_rdata !== 16'h0000) $display("FAIL rst_mid_rdata got=%h/%h exp=0000/0000", cpu_rdata, dma_rdata); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) acks++;
    end
    total_cnt++; if (acks != 0) $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); else pass_cnt++;
    rst_n = 1'b1;
    exp_addr = 16'h2222;
    watch(12);
    cpu_req = 1'b0;
    total_cnt++; if (ack_cyc != 4 || cpu_ack_cnt != 1) $display("FAIL rst_mid_regrant got ack_cyc=%0d acks=%0d exp 4/1", ack_cyc, cpu_ack_cnt); else pass_cnt++;
    total_cnt++; if (rd_cnt != 3 || addr_bad != 0) $display("FAIL rst_mid_regrant_bus got rd=%0d bad=%0d exp 3/0", rd_cnt, addr_bad); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'h7777) $display("FAIL rst_mid_rdata_after got=%h exp=7777", cpu_rdata); else pass_cnt++;
    step();
  endtask

  task automatic test_io_space();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000; mc_data_out = 16'h0041;
    exp_addr = 16'hC000;
    watch(12);
    cpu_req = 1'b0;
    total_cnt++; if (addr_bad != 0 || rd_cnt != 3) $display("FAIL io_addr got bad=%0d rd=%0d exp 0/3", addr_bad, rd_cnt); else pass_cnt++;
    total_cnt++; if (cpu_ack_cnt != 1) $display("FAIL io_ack got=%0d exp=1", cpu_ack_cnt); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'h0041) $display("FAIL io_rdata got=%h exp=0041", cpu_rdata); else pass_cnt++;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
    mc_data_out = 16'h0;
    exp_addr = 16'h0; exp_wdata = 16'h0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_access();
    test_io_space();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port arbiter and sequencer for the memory controller's single 16-bit word interface.
- Shares the controller between the CPU and a DMA/blitter requester.
- Holds the read or write enable for exactly the number of cycles a byte-serial SRAM word access needs, then inserts an idle cycle so the controller's byte counter resets.
- Returns read data plus a one-cycle acknowledge to the winning requester.

## Interface
- ACCESS_CYCLES, 3, cycles mc_read_en/mc_write_en are held per word; legal range 3..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid in the cpu_ack cycle and held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same widths and meanings for the DMA port.
- mc_address  out  16  to memory controller address_in.
- mc_data_in  out  16  to memory controller data_in.
- mc_data_out  in  16  from memory controller data_out.
- mc_read_en  out  1  memory controller read enable.
- mc_write_en  out  1  memory controller write enable.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  0 = CPU, 1 = DMA; the port currently (or last) granted.

## Operation
States: IDLE, ACCESS, COMPLETE.

**IDLE**
- Enables low.
- If any request is high, pick a winner (see Configuration).
- Latch the winner's we/addr/wdata into mc_address/mc_data_in and an internal we flag.
- Set owner and last_owner.
- Clear the cycle counter and go to ACCESS.

**ACCESS**
- mc_read_en = !we or mc_write_en = we; never both.
- Counter increments each cycle.
- When counter == ACCESS_CYCLES-1, go to COMPLETE.

**COMPLETE**
- Both enables low; this is the controller's reset cycle.
- For reads, capture mc_data_out into the owner's rdata.
- Pulse the owner's ack.
- Return to IDLE.

General rules:
- Requests are sampled only in IDLE. A request still high in the IDLE cycle after its ack counts as a new access.
- The losing requester waits with req held; no state is kept for it beyond req itself.
- mc_address/mc_data_in stay stable through ACCESS and COMPLETE. They are not cleared on return to IDLE.
- Owner is never switched mid-access.
- Addresses ≥ 0xC000 (I/O space) pass through unchanged; the arbiter applies no address decode.

## Timing
- Request seen high in IDLE at edge N:
  - enables high for cycles N+1 … N+ACCESS_CYCLES;
  - ack and rdata in cycle N+ACCESS_CYCLES+1;
  - next grant enables no earlier than N+ACCESS_CYCLES+3.
- Minimum spacing between accesses: ACCESS_CYCLES+2 cycles. At least 2 cycles with both enables low separate any two accesses.
- Ack is exactly one cycle wide. cpu_ack and dma_ack are never high together.
- Reset (async, any state, including mid-ACCESS):
  - state IDLE; enables, acks and busy 0;
  - mc_address, mc_data_in, cpu_rdata and dma_rdata 0;
  - owner 0, last_owner = DMA, counter 0.
  - An interrupted access produces no ack. The requester re-issues after reset.
- Request deasserted illegally before ack: the access still completes and the ack is still issued.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - on simultaneous cpu_req and dma_req in IDLE, grant the port that is not last_owner;
  - a single request is granted regardless of last_owner.
- Not defined: fixed priority; the CPU always wins a tie. DMA is granted only when cpu_req is low in IDLE. last_owner is still tracked but unused.

## Test plan
- CPU read, ACCESS_CYCLES=3, addr 0x1234, model returns 0xBEEF:
  - mc_read_en high exactly 3 cycles, mc_address=0x1234;
  - cpu_ack one cycle later with cpu_rdata=0xBEEF; dma_ack stays 0.
- DMA write, addr 0x0800, data 0xA55A:
  - mc_write_en high 3 cycles with mc_data_in=0xA55A;
  - mc_read_en never high; dma_ack pulses once; owner=1.
- cpu_req and dma_req both held high continuously for 4 accesses:
  - with ARB_ROUND_ROBIN_EN, ack order CPU, DMA, CPU, DMA;
  - without it, 4 cpu_acks and no dma_ack.
- Back-to-back CPU reads with req held through ack:
  - 2 enable-low cycles between enable bursts;
  - accesses spaced 5 cycles apart.
- rst_n pulsed low during cycle 2 of ACCESS:
  - enables drop asynchronously; no ack issued; all outputs 0;
  - after release, a pending cpu_req is granted from IDLE.
- Read of 0xC000 with mc_data_out=0x0041: passes through unchanged, cpu_rdata=0x0041.
